cpu_hazard_ctrl: RTL

Responder side of the hazard-detection interface. It consumes the register-use, load and branch/jump indications driven by the decode, execute and commit stages, and produces the pipeline `stall` consumed by fetch and decode. It also tracks stall episodes with a small FSM, raises a sticky watchdog error on over-long stalls, and keeps saturating per-cause performance counters. It sits beside the pipeline and is instantiated once per core.

---
 rtl/cpu_hazard_pkg.sv | 21 ++
 rtl/cpu_sat_counter.sv | 21 ++
 rtl/cpu_hazard_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cpu_hazard_pkg.sv
// Shared types for the pipeline hazard controller.
package cpu_hazard_pkg;

  localparam int unsigned CAUSE_W = 3;

  // Stall reason, ordered by priority (lowest non-zero value wins).
  typedef enum logic [CAUSE_W-1:0] {
    NONE    = 3'd0,
    LOAD_EX = 3'd1,
    LOAD_CM = 3'd2,
    BRANCH  = 3'd3,
    JUMP    = 3'd4
  } stall_cause_e;

  // Stall-episode tracker states.
  typedef enum logic {
    RUN     = 1'b0,
    STALLED = 1'b1
  } hz_state_e;

endpackage

// File: rtl/cpu_sat_counter.sv
// Saturating up-counter with a clear that overrides increment.
module cpu_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Clear beats increment; hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cpu_hazard_ctrl.sv
// Hazard detection: combinational stall, episode tracking, watchdog, perf counters.
module cpu_hazard_ctrl
  import cpu_hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned R0_ZERO     = 1,
  parameter int unsigned STALL_LIMIT = 8,
  parameter int unsigned CNT_W       = 32,
  localparam int unsigned RW         = $clog2(NUM_REGS),
  localparam int unsigned SRW        = $clog2(STALL_LIMIT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               execute_mem_read,
  input  logic               execute_wb,
  input  logic [RW-1:0]      execute_rd,
  input  logic               commit_mem_read,
  input  logic [RW-1:0]      commit_rd,
  input  logic [RW-1:0]      decode_ra,
  input  logic [RW-1:0]      decode_rb,
  input  logic               ra_use,
  input  logic               rb_use,
  input  logic               branch_decode,
  input  logic               jump_decode,
  input  logic               perf_clear,
  output logic               stall,
  output logic [CAUSE_W-1:0] stall_cause,
  output logic [SRW-1:0]     stall_run,
  output logic               wdog_err,
  output logic [CNT_W-1:0]   cnt_load,
  output logic [CNT_W-1:0]   cnt_branch,
  output logic [CNT_W-1:0]   cnt_jump,
  output logic [CNT_W-1:0]   cnt_episode
);

  localparam logic [SRW-1:0] RUN_MAX = SRW'(STALL_LIMIT);

  hz_state_e    state;
  stall_cause_e cause;
  logic         ex_a;
  logic         ex_b;
  logic         cm_any;
  logic [SRW-1:0] run_next;

  // A source operand matches r when it is read and r is not the hardwired zero.
  function automatic logic src_match(input logic used, input logic [RW-1:0] src,
                                     input logic [RW-1:0] r);
    return used && (src == r) && !((R0_ZERO != 0) && (r == '0));
  endfunction

  // Priority-encoded hazard cause; purely from current inputs.
  always_comb begin
    ex_a   = src_match(ra_use, decode_ra, execute_rd);
    ex_b   = src_match(rb_use, decode_rb, execute_rd);
    cm_any = src_match(ra_use, decode_ra, commit_rd) || src_match(rb_use, decode_rb, commit_rd);
    cause  = NONE;
    if (execute_mem_read && (ex_a || ex_b)) begin
      cause = LOAD_EX;
    end else if (commit_mem_read && cm_any) begin
      cause = LOAD_CM;
    end else if (branch_decode && execute_wb && (ex_a || ex_b)) begin
      cause = BRANCH;
    end else if (jump_decode && execute_wb && ex_a) begin
      cause = JUMP;
    end
  end

  assign stall       = (cause != NONE);
  assign stall_cause = cause;

  // Length of the current stall run after this edge.
  always_comb begin
    run_next = '0;
    if (stall) begin
      if (state == RUN) begin
        run_next = SRW'(1);
      end else if (stall_run != RUN_MAX) begin
        run_next = stall_run + SRW'(1);
      end else begin
        run_next = stall_run;
      end
    end
  end

  // Episode FSM, run length and sticky watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      stall_run <= '0;
      wdog_err  <= 1'b0;
    end else begin
      case (state)
        RUN:     if (stall)  state <= STALLED;
        STALLED: if (!stall) state <= RUN;
        default: state <= RUN;
      endcase
      stall_run <= run_next;
      if (run_next == RUN_MAX) begin
        wdog_err <= 1'b1;
      end
    end
  end

  cpu_sat_counter #(.W(CNT_W)) u_cnt_load (
    .clk   (clk),
    .reset (reset),
    .inc   ((cause == LOAD_EX) || (cause == LOAD_CM)),
    .clr   (perf_clear),
    .count (cnt_load)
  );

  cpu_sat_counter #(.W(CNT_W)) u_cnt_branch (
    .clk   (clk),
    .reset (reset),
    .inc   (cause == BRANCH),
    .clr   (perf_clear),
    .count (cnt_branch)
  );

  cpu_sat_counter #(.W(CNT_W)) u_cnt_jump (
    .clk   (clk),
    .reset (reset),
    .inc   (cause == JUMP),
    .clr   (perf_clear),
    .count (cnt_jump)
  );

  cpu_sat_counter #(.W(CNT_W)) u_cnt_episode (
    .clk   (clk),
    .reset (reset),
    .inc   (stall && (state == RUN)),
    .clr   (perf_clear),
    .count (cnt_episode)
  );

endmodule
